// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the load/store sequencer: state encoding,
// error codes and byte-lane geometry.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_ACCESS = 2'b01,
        S_DONE   = 2'b10,
        S_ERR    = 2'b11
    } state_t;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_CONFLICT = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    localparam int LANE_W = 8;

endpackage

// File: rtl/mem_access_unit_byte_lane_align.sv
// Combinational byte-lane steering: lane enables and byte replication on the
// store path, lane select plus sign/zero extension on the load path.
module byte_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic        st_byte,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_wdata,
    input  logic        ld_byte,
    input  logic        ld_sign,
    input  logic [1:0]  ld_off,
    input  logic [31:0] bus_rdata,
    output logic [31:0] ld_data
);

    logic [LANE_W-1:0] lane;

    always_comb begin
        // NOTE: every output gets a default first, so no path through the
        // block leaves it unassigned and no latch is inferred.
        bus_be    = 4'b1111;
        bus_wdata = st_data;
        ld_data   = bus_rdata;
        lane      = bus_rdata[ld_off*LANE_W +: LANE_W];
        if (st_byte) begin
            bus_be    = 4'b0001 << st_off;
            bus_wdata = {4{st_data[LANE_W-1:0]}};
        end
        if (ld_byte) begin
            ld_data = {{(32-LANE_W){ld_sign & lane[LANE_W-1]}}, lane};
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer: one word/byte access per request over a req/ack bus
// with wait states, timeout abort and a memory data register for write-back.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_rd,
    input  logic        req_wr,
    input  logic        byte_en,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mdr,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    state_t        state;
    logic [TW-1:0] wait_cnt;
    logic          lat_byte;
    logic          lat_sign;
    logic [1:0]    lat_off;
    logic [3:0]    st_be;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;

    // Store path steers the incoming request; load path uses the latched access.
    byte_lane_align u_align (
        .st_byte   (byte_en),
        .st_off    (addr[1:0]),
        .st_data   (wdata),
        .bus_be    (st_be),
        .bus_wdata (st_wdata),
        .ld_byte   (lat_byte),
        .ld_sign   (lat_sign),
        .ld_off    (lat_off),
        .bus_rdata (mem_rdata),
        .ld_data   (ld_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            wait_cnt  <= '0;
            lat_byte  <= 1'b0;
            lat_sign  <= 1'b0;
            lat_off   <= 2'b00;
            mdr       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            err_code  <= ERR_NONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every decision
            // below sees register values from before this edge.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (req_rd && req_wr) begin
                        err      <= 1'b1;
                        err_code <= ERR_CONFLICT;
                        state    <= S_ERR;
                    end else if ((req_rd || req_wr) && !byte_en && (addr[1:0] != 2'b00)) begin
                        err      <= 1'b1;
                        err_code <= ERR_MISALIGN;
                        state    <= S_ERR;
                    end else if (req_rd || req_wr) begin
                        lat_byte  <= byte_en;
                        lat_sign  <= sign_ext;
                        lat_off   <= addr[1:0];
                        mem_addr  <= {addr[31:2], 2'b00};
                        mem_be    <= st_be;
                        mem_wdata <= st_wdata;
                        mem_we    <= req_wr;
                        mem_req   <= 1'b1;
                        busy      <= 1'b1;
                        wait_cnt  <= '0;
                        state     <= S_ACCESS;
                    end
                end
                S_ACCESS: begin
                    if (mem_ack) begin
                        if (!mem_we) mdr <= ld_data;
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= S_DONE;
                    end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
                        // Abort: TIMEOUT request cycles have passed without an ack.
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        busy     <= 1'b0;
                        err      <= 1'b1;
                        err_code <= ERR_TIMEOUT;
                        state    <= S_ERR;
                    end else begin
                        wait_cnt <= wait_cnt + TW'(1);
                    end
                end
                S_DONE:  state <= S_IDLE;
                S_ERR:   state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: loads, stores, lane steering, error
// paths, timeout and asynchronous reset mid-access.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd, req_wr, byte_en, sign_ext;
    logic [31:0] addr, wdata;
    logic [31:0] mdr;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int n_checks = 0;
    int n_errors = 0;

    // Results of the last do_access call.
    int          req_cycles, done_cnt, err_cnt, lat;
    logic [3:0]  be_seen;
    logic        we_seen, stable;
    logic [31:0] addr_seen, wdata_seen;

    mem_access_unit #(.TIMEOUT(16), .TW(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_rd    (req_rd),
        .req_wr    (req_wr),
        .byte_en   (byte_en),
        .sign_ext  (sign_ext),
        .addr      (addr),
        .wdata     (wdata),
        .mdr       (mdr),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .err_code  (err_code),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issues one request, then plays the memory: ack on the ack_cycle-th
    // request cycle (0 = never). lat is cycles from request to done, or for
    // an err pulse, cycles from the first mem_req cycle (0 if none) to err.
    task automatic do_access(input logic rd, input logic wr, input logic be_in, input logic se,
                             input logic [31:0] a, input logic [31:0] wd,
                             input logic [31:0] rdat, input int ack_cycle);
        logic pulse_seen;
        req_rd = rd; req_wr = wr; byte_en = be_in; sign_ext = se;
        addr = a; wdata = wd; mem_rdata = rdat;
        tick();
        // Scramble the request inputs to prove the access was latched.
        req_rd = 1'b0; req_wr = 1'b0; byte_en = ~be_in; sign_ext = ~se;
        addr = ~a; wdata = ~wd;
        req_cycles = 0; done_cnt = 0; err_cnt = 0; lat = -1;
        stable = 1'b1; pulse_seen = 1'b0;
        be_seen = '0; we_seen = 1'b0; addr_seen = '0; wdata_seen = '0;
        for (int c = 0; c < 40; c++) begin
            if (done) begin done_cnt++; if (lat < 0) lat = c + 1; end
            if (err)  begin err_cnt++;  if (lat < 0) lat = c;     end
            if (busy !== mem_req) stable = 1'b0;
            if (mem_req) begin
                if (req_cycles == 0) begin
                    be_seen = mem_be; we_seen = mem_we;
                    addr_seen = mem_addr; wdata_seen = mem_wdata;
                end else if (mem_be !== be_seen || mem_we !== we_seen ||
                             mem_addr !== addr_seen || mem_wdata !== wdata_seen) begin
                    stable = 1'b0;
                end
                req_cycles++;
            end
            if (pulse_seen) break;
            if (done || err) pulse_seen = 1'b1;
            mem_ack = mem_req && (req_cycles == ack_cycle);
            tick();
            mem_ack = 1'b0;
        end
        if (!pulse_seen) check("access_terminated", 32'd0, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_rd = 1'b0; req_wr = 1'b0; byte_en = 1'b0; sign_ext = 1'b0;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #3;
        check("rst_mdr",      mdr, 32'h0);
        check("rst_outputs",  {30'd0, busy, done, err, err_code, mem_req, mem_we},
              32'h0);
        check("rst_bus",      {mem_addr[27:0], mem_be}, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // Word load, ack on 3rd request cycle.
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 3);
        check("wl_be",     be_seen, 32'hF);
        check("wl_we",     we_seen, 32'h0);
        check("wl_addr",   addr_seen, 32'h10);
        check("wl_mdr",    mdr, 32'hDEADBEEF);
        check("wl_done",   done_cnt, 32'd1);
        check("wl_busy",   req_cycles, 32'd3);
        check("wl_lat",    lat, 32'd4);
        check("wl_stable", stable, 32'd1);

        // Byte loads from lane 3, sign- and zero-extended.
        do_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h13, 32'h0, 32'h80FF0011, 2);
        check("bls_be",  be_seen, 32'h8);
        check("bls_mdr", mdr, 32'hFFFFFF80);
        do_access(1'b1, 1'b0, 1'b1, 1'b0, 32'h13, 32'h0, 32'h80FF0011, 1);
        check("blz_mdr", mdr, 32'h00000080);
        do_access(1'b1, 1'b0, 1'b1, 1'b1, 32'h11, 32'h0, 32'h80FF0011, 1);
        check("bl1_mdr", mdr, 32'h00000000);

        // Byte store with zero-wait ack.
        do_access(1'b0, 1'b1, 1'b1, 1'b0, 32'h22, 32'h123456AB, 32'h55555555, 1);
        check("bs_be",    be_seen, 32'h4);
        check("bs_wdata", wdata_seen, 32'hABABABAB);
        check("bs_we",    we_seen, 32'h1);
        check("bs_addr",  addr_seen, 32'h20);
        check("bs_lat",   lat, 32'd2);
        check("bs_mdr",   mdr, 32'h00000000);
        check("bs_done",  done_cnt, 32'd1);

        // Word store to a misaligned address.
        do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h05, 32'hCAFEF00D, 32'h0, 1);
        check("ma_err",  err_cnt, 32'd1);
        check("ma_code", err_code, 32'h1);
        check("ma_req",  req_cycles, 32'd0);
        check("ma_done", done_cnt, 32'd0);

        // Read and write requested together.
        do_access(1'b1, 1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 32'h0, 1);
        check("cf_err",  err_cnt, 32'd1);
        check("cf_code", err_code, 32'h2);
        check("cf_req",  req_cycles, 32'd0);

        // Word store, wait states, mdr must hold.
        do_access(1'b0, 1'b1, 1'b0, 1'b0, 32'h84, 32'h01234567, 32'hFFFFFFFF, 4);
        check("ws_wdata",  wdata_seen, 32'h01234567);
        check("ws_be",     be_seen, 32'hF);
        check("ws_stable", stable, 32'd1);
        check("ws_mdr",    mdr, 32'h00000000);
        check("ws_code",   err_code, 32'h2);

        // Stray ack with no request outstanding.
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("stray_ack", {done, err, busy}, 32'h0);

        // Load with no ack at all: timeout.
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h30, 32'h0, 32'h12345678, 0);
        check("to_err",  err_cnt, 32'd1);
        check("to_code", err_code, 32'h3);
        check("to_lat",  lat, 32'd16);
        check("to_req",  req_cycles, 32'd16);
        check("to_mdr",  mdr, 32'h00000000);
        check("to_done", done_cnt, 32'd0);
        check("to_reqlow", mem_req, 32'h0);

        // Asynchronous reset on the 2nd request cycle.
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h50, 32'h0, 32'hA5A5A5A5, 1);
        req_rd = 1'b1; byte_en = 1'b0; addr = 32'h60;
        tick();
        req_rd = 1'b0;
        tick();
        check("rs_req_before", mem_req, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("rs_req_async",  {busy, mem_req}, 32'h0);
        check("rs_mdr",        mdr, 32'h0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rs_no_pulse", {done, err}, 32'h0);
        end
        @(negedge clk);
        rst = 1'b0;
        tick();
        do_access(1'b1, 1'b0, 1'b0, 1'b0, 32'h44, 32'h0, 32'h0BADF00D, 2);
        check("rs_after_mdr",  mdr, 32'h0BADF00D);
        check("rs_after_done", done_cnt, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
